// File: rtl/osd_perm_scatter_seq_if.sv
// Job/result handshake bundle for the sequential scatter engine.
// The engine connects to the slave side; the producer/consumer connects to the master side.
interface osd_perm_scatter_seq_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = $clog2(N),
    parameter int unsigned DW    = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   lambda_flat;
    logic [N*DW-1:0]      data_flat;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*DW-1:0]      out_flat;
    logic                 perm_err;

    modport master (
        output in_valid, lambda_flat, data_flat, out_ready,
        input  in_ready, out_valid, out_flat, perm_err
    );

    modport slave (
        input  in_valid, lambda_flat, data_flat, out_ready,
        output in_ready, out_valid, out_flat, perm_err
    );
endinterface

// File: rtl/osd_perm_scatter_seq.sv
// Sequential scatter: y[lambda[i]] = x[i], one element per cycle, with permutation validation.
// Duplicate or out-of-range destinations are skipped and raise a sticky perm_err.
module osd_perm_scatter_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = $clog2(N),
    parameter int unsigned DW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    osd_perm_scatter_seq_if.slave bus,
    output logic                  busy
);
    localparam int unsigned IdxW = WIDTH + 1;
    localparam logic [WIDTH:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [WIDTH:0]     idx_q;
    logic [N-1:0]       written_q;
    logic [N*WIDTH-1:0] lam_q;
    logic [N*DW-1:0]    data_q;
    logic [N*DW-1:0]    out_q;
    logic               err_q;

    logic [WIDTH-1:0]   dest;
    logic [DW-1:0]      elem;
    logic [N-1:0]       dest_onehot;
    logic               dest_hit;
    logic               dest_taken;

    // dest_hit stays low for a destination >= N, so the range check falls out of the decode.
    always_comb begin
        dest        = '0;
        elem        = '0;
        dest_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IdxW'(k)) begin
                dest = lam_q[k*WIDTH +: WIDTH];
                elem = data_q[k*DW +: DW];
            end
        end
        for (int k = 0; k < N; k++) begin
            dest_onehot[k] = (dest == WIDTH'(k));
        end
        dest_hit   = |dest_onehot;
        dest_taken = |(dest_onehot & written_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            written_q <= '0;
            lam_q     <= '0;
            data_q    <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        lam_q     <= bus.lambda_flat;
                        data_q    <= bus.data_flat;
                        out_q     <= '0;
                        written_q <= '0;
                        err_q     <= 1'b0;
                        idx_q     <= '0;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (!dest_hit || dest_taken) begin
                        err_q <= 1'b1;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            if (dest_onehot[k]) out_q[k*DW +: DW] <= elem;
                        end
                        written_q <= written_q | dest_onehot;
                    end
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_flat  = out_q;
    assign bus.perm_err  = err_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_osd_perm_scatter_seq.sv
// Self-checking bench: directed and random jobs against an array-based scatter model.
module tb_osd_perm_scatter_seq;
    localparam int N  = 8;
    localparam int W  = 3;
    localparam int DW = 8;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic rst;
    logic busy, busy6;
    always #5 clk = ~clk;

    osd_perm_scatter_seq_if #(.N(N),  .WIDTH(W), .DW(DW)) bus ();
    osd_perm_scatter_seq_if #(.N(N6), .WIDTH(W), .DW(DW)) bus6 ();

    osd_perm_scatter_seq #(.N(N), .WIDTH(W), .DW(DW)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    osd_perm_scatter_seq #(.N(N6), .WIDTH(W), .DW(DW)) u_dut6 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus6.slave),
        .busy (busy6)
    );

    int checks = 0;
    int errors = 0;
    int lam[8];
    logic [7:0] dat[8];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference scatter: first valid claim on a position wins, everything else is an error.
    function automatic void model(input int n, input int l[8], input logic [7:0] x[8],
                                  output logic [63:0] y, output logic err);
        bit seen[8];
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        y   = '0;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (l[i] >= n || seen[l[i]]) begin
                err = 1'b1;
            end else begin
                seen[l[i]] = 1'b1;
                y[l[i]*8 +: 8] = x[i];
            end
        end
    endfunction

    task automatic run_job(input string tag, input int hold, input bit early);
        logic [63:0] ey;
        logic        eerr;
        int          cyc;
        model(N, lam, dat, ey, eerr);
        @(negedge clk);
        check_val({tag, " in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < N; i++) begin
            bus.lambda_flat[i*W +: W] = W'(lam[i]);
            bus.data_flat[i*DW +: DW] = dat[i];
        end
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.lambda_flat = W*N'($urandom);
        bus.data_flat   = {$urandom, $urandom};
        if (early) bus.out_ready = 1'b1;
        @(negedge clk);
        check_val({tag, " busy_run"}, 64'(busy), 64'd1);
        check_val({tag, " in_ready_run"}, 64'(bus.in_ready), 64'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 4 * N) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " latency"}, 64'(cyc), 64'(N));
        check_val({tag, " out_flat"}, bus.out_flat, ey);
        check_val({tag, " perm_err"}, 64'(bus.perm_err), 64'(eerr));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_val({tag, " hold_out"}, bus.out_flat, ey);
                check_val({tag, " hold_err"}, 64'(bus.perm_err), 64'(eerr));
                check_val({tag, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
                check_val({tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, " in_ready_after"}, 64'(bus.in_ready), 64'd1);
        check_val({tag, " valid_after"}, 64'(bus.out_valid), 64'd0);
        check_val({tag, " out_kept_idle"}, bus.out_flat, ey);
    endtask

    task automatic run6(input string tag);
        logic [63:0] ey;
        logic        eerr;
        int          cyc;
        model(N6, lam, dat, ey, eerr);
        @(negedge clk);
        for (int i = 0; i < N6; i++) begin
            bus6.lambda_flat[i*W +: W] = W'(lam[i]);
            bus6.data_flat[i*DW +: DW] = dat[i];
        end
        bus6.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus6.in_valid = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!bus6.out_valid && cyc < 4 * N6) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " latency"}, 64'(cyc), 64'(N6));
        check_val({tag, " out_flat"}, 64'(bus6.out_flat), ey);
        check_val({tag, " perm_err"}, 64'(bus6.perm_err), 64'(eerr));
        bus6.out_ready = 1'b1;
        @(negedge clk);
        bus6.out_ready = 1'b0;
        check_val({tag, " in_ready_after"}, 64'(bus6.in_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.lambda_flat  = '0;
        bus.data_flat    = '0;
        bus6.in_valid    = 1'b0;
        bus6.out_ready   = 1'b0;
        bus6.lambda_flat = '0;
        bus6.data_flat   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst out_flat", bus.out_flat, 64'd0);
        check_val("rst perm_err", 64'(bus.perm_err), 64'd0);

        for (int i = 0; i < N; i++) begin
            lam[i] = i;
            dat[i] = 8'(8'h10 + i);
        end
        run_job("identity", 0, 1'b0);

        for (int i = 0; i < N; i++) begin
            lam[i] = N - 1 - i;
            dat[i] = 8'(8'hA0 + i);
        end
        run_job("reversal", 1, 1'b0);
        // Gather with the inverse permutation must recover the source vector.
        for (int i = 0; i < N; i++) begin
            check_val("reversal gather", 64'(bus.out_flat[lam[i]*DW +: DW]), 64'(dat[i]));
        end

        lam = '{3, 3, 0, 1, 2, 4, 5, 6};
        for (int i = 0; i < N; i++) dat[i] = 8'(i + 1);
        run_job("duplicate", 5, 1'b0);
        check_val("duplicate pos3", 64'(bus.out_flat[3*DW +: DW]), 64'd1);
        check_val("duplicate pos7", 64'(bus.out_flat[7*DW +: DW]), 64'd0);

        // Immediate second job after the backpressured one.
        for (int i = 0; i < N; i++) begin
            lam[i] = (i + 3) % N;
            dat[i] = 8'($urandom);
        end
        run_job("back_to_back", 0, 1'b0);
        run_job("early_ready", 0, 1'b1);

        // Reset in the middle of RUN at idx=4.
        for (int i = 0; i < N; i++) begin
            lam[i] = N - 1 - i;
            dat[i] = 8'($urandom);
            bus.lambda_flat[i*W +: W] = W'(lam[i]);
            bus.data_flat[i*DW +: DW] = dat[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("midrst in_ready", 64'(bus.in_ready), 64'd1);
        check_val("midrst out_valid", 64'(bus.out_valid), 64'd0);
        check_val("midrst busy", 64'(busy), 64'd0);
        check_val("midrst out_flat", bus.out_flat, 64'd0);
        check_val("midrst perm_err", 64'(bus.perm_err), 64'd0);
        for (int i = 0; i < N; i++) begin
            lam[i] = i;
            dat[i] = 8'(8'h10 + i);
        end
        run_job("post_rst_identity", 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            int mode;
            mode = $urandom_range(1, 0);
            for (int i = 0; i < N; i++) begin
                lam[i] = i;
                dat[i] = 8'($urandom);
            end
            if (mode == 0) begin
                for (int i = N - 1; i > 0; i--) begin
                    int j, tmp;
                    j = $urandom_range(i, 0);
                    tmp = lam[i];
                    lam[i] = lam[j];
                    lam[j] = tmp;
                end
            end else begin
                for (int i = 0; i < N; i++) lam[i] = $urandom_range(N - 1, 0);
            end
            run_job("random", $urandom_range(3, 0), ($urandom_range(3, 0) == 0));
        end

        // Non-power-of-two instance: entry 7 is out of range.
        lam = '{0, 1, 2, 3, 4, 7, 0, 0};
        for (int i = 0; i < 8; i++) dat[i] = 8'(i + 1);
        run6("n6_range");
        check_val("n6_range pos5", 64'(bus6.out_flat[5*DW +: DW]), 64'd0);
        lam = '{5, 2, 0, 4, 1, 3, 0, 0};
        for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
        run6("n6_perm");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
